// File: rtl/tdm_mux4_pkg.sv
// Shared constants and types for the 4-to-1 TDM multiplexer.
package tdm_mux4_pkg;

  localparam int unsigned CH_N  = 4;
  localparam int unsigned SEL_W = 2;

  // Priority pointer after reset: the search starts at ptr+1, so channel 0 goes first.
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way arbiter. Round-robin starting after ptr by default;
// with TDM_MUX4_FIXED_PRIO_EN defined, fixed priority (channel 0 highest) and ptr is ignored.
module rr_arbiter4
  import tdm_mux4_pkg::*;
(
  input  logic [CH_N-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [CH_N-1:0]  grant,
  output logic [SEL_W-1:0] grant_idx
);

`ifdef TDM_MUX4_FIXED_PRIO_EN
  logic [SEL_W-1:0] unused_ptr;
  assign unused_ptr = ptr;
`endif

  // Pick the first requester in search order; nothing is granted when disabled.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < CH_N; k++) begin
`ifdef TDM_MUX4_FIXED_PRIO_EN
      idx = SEL_W'(k);
`else
      idx = ptr + SEL_W'(k + 1);
`endif
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/tdm_mux4.sv
// Sequential 4-to-1 multiplexer: four valid/ready lanes share one registered output
// carrying the word and its channel index. Optional macro TDM_MUX4_FIXED_PRIO_EN selects
// fixed priority instead of round-robin (applied inside rr_arbiter4; ptr then stays at reset).
module tdm_mux4
  import tdm_mux4_pkg::*;
#(
  parameter int unsigned DATA_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH_N*DATA_W-1:0] in_data,
  input  logic [CH_N-1:0]        in_valid,
  output logic [CH_N-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_valid,
  input  logic                   out_ready
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               space;
  logic               grant_any;
  logic [SEL_W-1:0]   grant_idx;

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  // Room for a new word when empty or when the held word leaves this cycle.
  assign space     = (state_q == ST_EMPTY) | (out_ready & out_valid);
  assign grant_any = |in_ready;

  rr_arbiter4 u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .en        (space & ~rst),
    .grant     (in_ready),
    .grant_idx (grant_idx)
  );

  // Next-state for FSM, output register and priority pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_EMPTY: if (grant_any) state_d = ST_FULL;
      ST_FULL:  if (out_ready) state_d = grant_any ? ST_FULL : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (grant_any) begin
      data_d = in_data[grant_idx*DATA_W +: DATA_W];
      sel_d  = grant_idx;
`ifndef TDM_MUX4_FIXED_PRIO_EN
      ptr_d  = grant_idx;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= PTR_RST;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_tdm_mux4.sv
// Scoreboard bench for tdm_mux4: accepted input words are queued with their channel
// and compared when the output handshake retires them.
module tb_tdm_mux4;

  localparam int unsigned DW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0]    in_valid = 4'hf;
  logic [3:0]    in_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  logic [1:0]  m_ptr = 2'd3;
  logic        m_full = 1'b0;
  logic        m_zero = 1'b1;
  logic        m_stall = 1'b0;
  logic [1:0]  hold_sel;
  logic [DW-1:0] hold_data;
  logic [DW+1:0] sb_q[$];

  tdm_mux4 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor/model on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [3:0]  exp_rdy;
    logic [1:0]  idx;
    logic [DW+1:0] item;
    int g;
    exp_rdy = '0;
    g = -1;
    if (!rst && (!m_full || out_ready)) begin
      for (int k = 1; k <= 4; k++) begin
`ifdef TDM_MUX4_FIXED_PRIO_EN
        idx = 2'(k - 1);
`else
        idx = m_ptr + 2'(k);
`endif
        if (g < 0 && in_valid[idx]) g = int'(idx);
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_full));
    if (m_zero) begin
      check("reset_out_data", 32'(out_data), 32'd0);
      check("reset_out_sel", 32'(out_sel), 32'd0);
    end
    if (m_stall) begin
      check("stall_sel", 32'(out_sel), 32'(hold_sel));
      check("stall_data", 32'(out_data), 32'(hold_data));
    end
    if (!rst && m_full && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        item = sb_q.pop_front();
        check("out_sel", 32'(out_sel), 32'(item[DW+1:DW]));
        check("out_data", 32'(out_data), 32'(item[DW-1:0]));
      end
    end
    // Advance model to the state after the coming rising edge.
    m_stall = !rst && m_full && !out_ready;
    hold_sel = out_sel;
    hold_data = out_data;
    if (rst) begin
      m_full = 1'b0;
      m_ptr  = 2'd3;
      m_zero = 1'b1;
      sb_q.delete();
    end else if (g >= 0) begin
      sb_q.push_back({2'(g), in_data[g*DW +: DW]});
      m_full = 1'b1;
      m_zero = 1'b0;
`ifndef TDM_MUX4_FIXED_PRIO_EN
      m_ptr  = 2'(g);
`endif
    end else if (out_ready) begin
      m_full = 1'b0;
    end
  end

  task automatic step(input logic r, input logic [3:0] v, input logic ordy,
                      input logic [4*DW-1:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = r;
      in_valid = v;
      out_ready = ordy;
      in_data = d;
    end
  endtask

  localparam logic [4*DW-1:0] IdxData = {2'd3, 2'd2, 2'd1, 2'd0};

  initial begin
    // Reset held with all channels requesting.
    step(1'b1, 4'hf, 1'b1, IdxData, 2);
    // Round-robin with all valid; words carry their channel index.
    step(1'b0, 4'hf, 1'b1, IdxData, 9);
    // Single requester, channel 2 carrying 1.
    step(1'b0, 4'b0100, 1'b1, 8'b00_01_00_00, 3);
    // Load channel 1, then stall with all valid, then release.
    step(1'b0, 4'b0010, 1'b1, IdxData, 1);
    step(1'b0, 4'hf, 1'b0, IdxData, 3);
    step(1'b0, 4'hf, 1'b1, IdxData, 2);
    // Wrap and skip: grant ch3, then only ch1/ch3.
    step(1'b0, 4'b1000, 1'b1, IdxData, 1);
    step(1'b0, 4'b1010, 1'b1, 8'b10_01_11_00, 6);
    // Idle drain.
    step(1'b0, 4'b0000, 1'b1, IdxData, 3);
    // Mid-operation reset while a word is held and stalled.
    step(1'b0, 4'hf, 1'b0, IdxData, 3);
    step(1'b1, 4'hf, 1'b0, IdxData, 1);
    step(1'b0, 4'hf, 1'b1, IdxData, 4);
    // Randomised traffic and backpressure.
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 4'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom), 1);
    end
    step(1'b0, 4'b0000, 1'b1, IdxData, 3);
    @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdm_mux4.md
Name: tdm_mux4

Overview:
- Sequential 4-to-1 multiplexer. It is the gathering counterpart of the lab1 1-to-4 demultiplexer.
- Four input channels, each with valid/ready, compete for one registered output stream.
- A round-robin arbiter picks the channel. The output carries the data plus a 2-bit channel select, so a downstream demultiplexer can route each word back to lane out_sel.
- Sits between four producer lanes and a single shared link.

Parameters:
- DATA_W, 1, width of each channel's data word.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  4*DATA_W  channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  4  per-channel valid.
- in_ready  output  4  per-channel ready; at most one bit set per cycle.
- out_data  output  DATA_W  registered selected word.
- out_sel  output  2  registered channel index of out_data; {x1,x2} order: out_sel[1]=x1, out_sel[0]=x2.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: out_valid=0, out_data=0, out_sel=0, state=EMPTY, priority pointer ptr=3, so channel 0 has first priority.
- State machine (2 states):
  - EMPTY: output register holds no word.
  - FULL: output register holds a word (out_valid=1).
- Space condition: space = (state==EMPTY) | (out_ready & out_valid).
- Grant:
  - When space=1 and any in_valid is set, grant the first valid channel searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - in_ready is one-hot at the granted channel, otherwise 0.
  - in_ready is combinational from in_valid, ptr and state. It never depends on in_data.
- On a grant (in_valid[g] & in_ready[g]):
  - Next cycle: out_data=in_data[g], out_sel=g, out_valid=1, ptr=g.
  - Latency is exactly 1 cycle from input handshake to out_valid.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on out_ready with no grant.
  - FULL→FULL on out_ready with a grant: back-to-back, full throughput of 1 word/cycle.
  - FULL stall (out_ready=0): out_data, out_sel and out_valid hold stable, all in_ready=0, ptr unchanged.
- Wrap-around: ptr=3 searches 0,1,2,3; ptr arithmetic is 2-bit modulo.
- Simultaneous requests, all four valid continuously with out_ready=1: grant order 0,1,2,3,0,...
- Single requester: the same channel may be granted every cycle.
- No valid inputs: no grant, ptr unchanged.
- Reset mid-operation: a held word is discarded, outputs return to reset values the following cycle, and in_ready=0 while rst=1.
- An input may deassert in_valid without a handshake; no state changes.

Optional Feature:
- Macro: TDM_MUX4_FIXED_PRIO_EN.
- Defined: fixed priority, channel 0 highest, then 1, 2, 3. ptr is not updated and does not affect the search; everything else is unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package tdm_mux4_pkg:
  - CH_N=4, SEL_W=2.
  - State encoding ST_EMPTY=1'b0, ST_FULL=1'b1.
  - PTR_RST=2'd3.
- Sub-module rr_arbiter4: inputs req[4], ptr[2], en; outputs grant[4] (one-hot) and grant_idx[2]. It is purely combinational, and the fixed-priority macro is applied inside it.
- tdm_mux4 holds the state, ptr and output register.

Test Plan:
- Reset, DATA_W=1: rst=1 for 2 cycles with all in_valid=1 → in_ready=0000, out_valid=0, out_sel=0, out_data=0. The first cycle after release grants ch0.
- Single channel: in_valid=0100, in_data ch2=1, out_ready=1 → in_ready=0100 at cycle 0; cycle 1 out_valid=1, out_sel=2, out_data=1.
- Round-robin: all valid, in_data = channel index (DATA_W=2), out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3, out_data equals out_sel, out_valid stays 1.
- Backpressure: output FULL with sel=1, out_ready=0 for 3 cycles with all valid → out_sel/out_data stable, in_ready=0000. On release, the next grant is ch2.
- Wrap and skip: ptr=3 after a ch3 grant, then only in_valid=1010 → grants ch1 then ch3 alternately.
- Mid-operation reset: rst pulses while out_valid=1 → next cycle out_valid=0, out_data=0, out_sel=0, and the first post-reset grant is ch0.
- Macro: build with TDM_MUX4_FIXED_PRIO_EN, all valid → out_sel=0 every cycle.
